ula_sequencial: RTL and testbench

Parametrised, clocked successor of the board-level 4-bit ALU. It registers operands on a `start` strobe and executes add, sub, AND, OR, XOR in one cycle. Multiply and divide run as iterative shift-add and restoring-divide engines taking `WIDTH` cycles. It returns a registered `2*WIDTH`-bit result with flags and a `busy`/`done` handshake. It sits between the switch/key input stage and the BCD/7-segment display path, and holds its last result until the next accepted operation.

---
 rtl/ula_sequencial.sv | 205 ++++++++++++++++++++
 tb/tb_ula_sequencial.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencial.sv
// Sequential ALU: add/sub/logic in one cycle, shift-add multiply and restoring divide over WIDTH cycles.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for mult/div (b!=0) from start to end of done.
// Backpressure: start is taken only while busy=0; a start seen during busy is dropped, never queued.
module ula_sequencial #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    output logic [2*WIDTH-1:0] resultado,
    output logic               busy,
    output logic               done,
    output logic               flag_zero,
    output logic               flag_cout,
    output logic               flag_ov,
    output logic               flag_neg,
    output logic               flag_erro
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic          accept;
    logic          iter_op;
    logic          last_iter;
    logic [CW-1:0] cnt;
    logic          run_div;

    // Iterative engine state: multiplier path and divider path kept separate for readability.
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [RW-1:0]    prod;
    logic [RW-1:0]    prod_nxt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [RW-1:0]    iter_res;

    // Single-cycle results
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [RW-1:0]    sc_res;
    logic             sc_cout;
    logic             sc_ov;
    logic             sc_neg;
    logic             sc_erro;

    assign accept    = start && (state == IDLE);
    assign iter_op   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign last_iter = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && iter_op) state_nxt = RUN;
            RUN:     if (last_iter)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff    = {1'b0, a} - {1'b0, b};
        sc_res  = '0;
        sc_cout = 1'b0;
        sc_ov   = 1'b0;
        sc_neg  = 1'b0;
        sc_erro = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res  = {{(WIDTH-1){1'b0}}, sum};
                sc_cout = sum[WIDTH];
                sc_ov   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                sc_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                sc_neg = diff[WIDTH];
            end
            OP_AND: sc_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:  sc_res = {{WIDTH{1'b0}}, a | b};
            OP_XOR: sc_res = {{WIDTH{1'b0}}, a ^ b};
            // Only reachable here with b==0: remainder=a, quotient saturates to all ones.
            OP_DIV: begin
                sc_res  = {a, {WIDTH{1'b1}}};
                sc_erro = 1'b1;
            end
            default: begin
                sc_res  = '0;
                sc_erro = 1'b1;
            end
        endcase
    end

    // ---------------- iterative datapath ----------------
    always_comb begin
        prod_nxt = mplier[0] ? (prod + mcand) : prod;
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        // Non-negative trial means the divisor fits: keep the difference and emit a 1.
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
        iter_res = run_div ? {rem_nxt, quo_nxt} : prod_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultado <= '0;
            done      <= 1'b0;
            flag_zero <= 1'b0;
            flag_cout <= 1'b0;
            flag_ov   <= 1'b0;
            flag_neg  <= 1'b0;
            flag_erro <= 1'b0;
            cnt       <= '0;
            run_div   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mcand   <= {{WIDTH{1'b0}}, a};
                mplier  <= b;
                prod    <= '0;
                quo     <= a;
                rem     <= '0;
                divisor <= b;
                cnt     <= '0;
                run_div <= (op == OP_DIV);
                if (!iter_op) begin
                    resultado <= sc_res;
                    flag_zero <= (sc_res == '0);
                    flag_cout <= sc_cout;
                    flag_ov   <= sc_ov;
                    flag_neg  <= sc_neg;
                    flag_erro <= sc_erro;
                    done      <= 1'b1;
                end
            end else if (state == RUN) begin
                prod   <= prod_nxt;
                mcand  <= {mcand[RW-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
                rem    <= rem_nxt;
                quo    <= quo_nxt;
                cnt    <= cnt + CW'(1);
                if (last_iter) begin
                    resultado <= iter_res;
                    flag_zero <= (iter_res == '0);
                    flag_cout <= 1'b0;
                    flag_ov   <= 1'b0;
                    flag_neg  <= 1'b0;
                    flag_erro <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench for ula_sequencial: vector table at WIDTH=4 plus hand sequences and a WIDTH=8 instance.
module tb_ula_sequencial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] resultado;
    logic       busy;
    logic       done;
    logic       flag_zero, flag_cout, flag_ov, flag_neg, flag_erro;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic [15:0] resultado8;
    logic        busy8;
    logic        done8;
    logic        fz8, fc8, fo8, fn8, fe8;

    int total = 0;
    int bad   = 0;

    ula_sequencial #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .resultado(resultado), .busy(busy), .done(done),
        .flag_zero(flag_zero), .flag_cout(flag_cout), .flag_ov(flag_ov),
        .flag_neg(flag_neg), .flag_erro(flag_erro)
    );

    ula_sequencial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8), .cin(cin8),
        .resultado(resultado8), .busy(busy8), .done(done8),
        .flag_zero(fz8), .flag_cout(fc8), .flag_ov(fo8),
        .flag_neg(fn8), .flag_erro(fe8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [7:0] res;
        logic [4:0] flags;   // {cout, ov, neg, erro, zero}
        int         bcyc;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] flags4();
        return {flag_cout, flag_ov, flag_neg, flag_erro, flag_zero};
    endfunction

    // Issue one op on the WIDTH=4 unit, scramble operands after accept, wait for done.
    task automatic run4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        input logic c, output int bcyc, output bit ok);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cin = c;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = ~y; cin = ~c;
        bcyc = 0;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int bcyc, output bit ok);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~x; b8 = ~y;
        bcyc = 0;
        ok   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done8) begin
                ok = 1'b1;
                break;
            end
            if (busy8) bcyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  bc;
        bit  ok;
        int  extra;
        bit  saw;

        vt[0]  = '{3'b000, 4'd9,  4'd8, 1'b1, 8'h12, 5'b11000, 0};
        vt[1]  = '{3'b001, 4'd3,  4'd5, 1'b0, 8'h0E, 5'b00100, 0};
        vt[2]  = '{3'b001, 4'd5,  4'd5, 1'b0, 8'h00, 5'b00001, 0};
        vt[3]  = '{3'b010, 4'hC,  4'hA, 1'b1, 8'h08, 5'b00000, 0};
        vt[4]  = '{3'b011, 4'hC,  4'hA, 1'b1, 8'h0E, 5'b00000, 0};
        vt[5]  = '{3'b101, 4'hC,  4'hA, 1'b0, 8'h06, 5'b00000, 0};
        vt[6]  = '{3'b100, 4'd15, 4'd15, 1'b0, 8'hE1, 5'b00000, 4};
        vt[7]  = '{3'b110, 4'd13, 4'd4, 1'b0, 8'h13, 5'b00000, 4};
        vt[8]  = '{3'b110, 4'd13, 4'd0, 1'b0, 8'hDF, 5'b00010, 0};
        vt[9]  = '{3'b111, 4'd7,  4'd7, 1'b0, 8'h00, 5'b00011, 0};
        vt[10] = '{3'b000, 4'hF,  4'h0, 1'b1, 8'h10, 5'b10000, 0};
        vt[11] = '{3'b001, 4'd8,  4'd1, 1'b0, 8'h07, 5'b01000, 0};
        vt[12] = '{3'b100, 4'd0,  4'd7, 1'b0, 8'h00, 5'b00001, 4};
        vt[13] = '{3'b110, 4'd7,  4'd9, 1'b0, 8'h70, 5'b00000, 4};
        vt[14] = '{3'b000, 4'd7,  4'd1, 1'b0, 8'h08, 5'b01000, 0};
        vt[15] = '{3'b100, 4'd3,  4'd5, 1'b0, 8'h0F, 5'b00000, 4};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res",   32'(resultado), 32'h0);
        chk("reset_busy",  32'(busy), 32'h0);
        chk("reset_done",  32'(done), 32'h0);
        chk("reset_flags", 32'(flags4()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run4(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, bc, ok);
            chk($sformatf("vec%0d_done", i), 32'(ok), 32'h1);
            chk($sformatf("vec%0d_res", i), 32'(resultado), 32'(vt[i].res));
            chk($sformatf("vec%0d_flags", i), 32'(flags4()), 32'(vt[i].flags));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vt[i].bcyc));
        end

        // start during busy must be dropped: no extra done, result stays the product
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 4'd15; b = 4'd15; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 4'd1; b = 4'd1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ignore_done_seen", 32'(ok), 32'h1);
        chk("ignore_res", 32'(resultado), 32'hE1);
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("ignore_extra_done", 32'(extra), 32'h0);
        chk("ignore_res_held", 32'(resultado), 32'hE1);

        // back-to-back single-cycle ops: start held through the done cycle
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 4'd1; b = 4'd2; cin = 1'b0;
        @(posedge clk); #1;
        chk("b2b_first_done", 32'(done), 32'h1);
        chk("b2b_first_res", 32'(resultado), 32'h03);
        @(negedge clk);
        a = 4'd3; b = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_done", 32'(done), 32'h1);
        chk("b2b_second_res", 32'(resultado), 32'h07);

        // reset two cycles into a multiply
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 4'd15; b = 4'd15;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_res", 32'(resultado), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_flags", 32'(flags4()), 32'h0);
        saw = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        chk("abort_no_done", 32'(saw), 32'h0);
        run4(3'b000, 4'd1, 4'd1, 1'b0, bc, ok);
        chk("post_abort_done", 32'(ok), 32'h1);
        chk("post_abort_res", 32'(resultado), 32'h02);

        // WIDTH=8 instance
        run8(3'b100, 8'd255, 8'd255, bc, ok);
        chk("w8_mul_done", 32'(ok), 32'h1);
        chk("w8_mul_res", 32'(resultado8), 32'hFE01);
        chk("w8_mul_busy_cycles", 32'(bc), 32'd8);
        run8(3'b110, 8'd200, 8'd7, bc, ok);
        chk("w8_div_done", 32'(ok), 32'h1);
        chk("w8_div_res", 32'(resultado8), 32'h041C);
        chk("w8_div_busy_cycles", 32'(bc), 32'd8);
        chk("w8_div_erro", 32'(fe8), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
